// File: rtl/gray_pkg.sv
// Shared definitions for the Gray counter sequencer.
// Holds the controller state encoding, the default counter width and the
// binary <-> Gray conversion helpers. The helpers work on a 32-bit
// zero-extended value, so they serve any width W <= 32. The caller narrows
// the result with W'(...).
package gray_pkg;

    // Default width of the driven JK Gray counter.
    localparam int unsigned GRAY_W = 4;

    // Internal width of the conversion helpers.
    localparam int unsigned CONV_W = 32;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ADV   = 3'd2,
        ST_CHK   = 3'd3,
        ST_FIN   = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // Binary to reflected Gray code.
    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary: each bit is the XOR of all Gray bits at
    // and above it. Zero-extended upper bits do not disturb the result.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray to binary converter.
// Ports:
//   gray  - W-bit Gray-coded input
//   bin_c - W-bit binary equivalent (combinational)
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int unsigned W = GRAY_W
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin_c
);

    assign bin_c = W'(gray2bin(CONV_W'(gray)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Sequencer and checker for a JK-based Gray code counter.
// The controller drives the counter's shared J/K toggle enable so that the
// counter advances an exact number of steps. After each advance it reads QN
// back and checks that QN holds the next Gray code.
// Ports:
//   CLK   - clock. All state updates on the rising edge.
//   RST   - synchronous, active-high reset
//   START - pulse: begin a run of STEPS advances (wins over STEP)
//   STEP  - pulse: perform a single advance
//   STOP  - abort a run at the next step boundary
//   STEPS - requested advance count, sampled on accepted START
//   QN    - counter output fed back for checking
//   J, K  - counter toggle drive (K always equals J)
//   BUSY  - high outside IDLE and ERROR
//   DONE  - one-cycle pulse when a run or step completes normally
//   ERR   - sticky readback-mismatch flag
//   POS   - binary position of the last verified QN
module gray_seq_ctrl
    import gray_pkg::*;
#(
    parameter int unsigned W     = GRAY_W,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STEP,
    input  logic             STOP,
    input  logic [CNT_W-1:0] STEPS,
    input  logic [W-1:0]     QN,
    output logic             J,
    output logic             K,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [W-1:0]     POS
);

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_LOAD  = 3'(ST_LOAD);
    localparam logic [2:0] S_ADV   = 3'(ST_ADV);
    localparam logic [2:0] S_CHK   = 3'(ST_CHK);
    localparam logic [2:0] S_FIN   = 3'(ST_FIN);
    localparam logic [2:0] S_ERROR = 3'(ST_ERROR);

    logic [2:0]       state,     state_nx;
    logic [CNT_W-1:0] rem,       rem_nx;
    logic [W-1:0]     base,      base_nx;
    logic [W-1:0]     expv,      expv_nx;
    logic             stop_pend, stop_pend_nx;
    logic [W-1:0]     pos_nx;
    logic             err_nx;

    logic [W-1:0]     qn_bin;
    logic [W-1:0]     base_inc;
    logic [CNT_W-1:0] rem_dec;
    logic             stop_seen;

    // Current counter position decoded from the readback.
    gray_to_bin #(
        .W (W)
    ) u_qn_dec (
        .gray  (QN),
        .bin_c (qn_bin)
    );

    // The addition wraps modulo 2^W at the top of the range.
    assign base_inc  = base + W'(1);
    assign rem_dec   = rem - CNT_W'(1);
    assign stop_seen = stop_pend | STOP;

    // J and K are always driven together.
    assign K = J;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and next values of the datapath registers.
    always_comb begin
        state_nx     = state;
        rem_nx       = rem;
        base_nx      = base;
        expv_nx      = expv;
        stop_pend_nx = stop_pend;
        pos_nx       = POS;
        err_nx       = ERR;

        case (state)
            S_IDLE: begin
                stop_pend_nx = 1'b0;
                if (START) begin
                    rem_nx   = STEPS;
                    state_nx = S_LOAD;
                end else if (STEP) begin
                    rem_nx   = CNT_W'(1);
                    state_nx = S_LOAD;
                end
            end

            S_LOAD: begin
                stop_pend_nx = 1'b0;
                base_nx      = qn_bin;
                pos_nx       = qn_bin;
                state_nx     = (rem == '0) ? S_FIN : S_ADV;
            end

            // The counter toggles on the edge that ends this state.
            S_ADV: begin
                stop_pend_nx = stop_seen;
                expv_nx      = W'(bin2gray(CONV_W'(base_inc)));
                state_nx     = S_CHK;
            end

            // A normal completion takes priority over a pending stop.
            S_CHK: begin
                stop_pend_nx = stop_seen;
                if (QN != expv) begin
                    err_nx   = 1'b1;
                    state_nx = S_ERROR;
                end else begin
                    base_nx = base_inc;
                    pos_nx  = base_inc;
                    rem_nx  = rem_dec;
                    if (rem_dec == '0) begin
                        state_nx = S_FIN;
                    end else if (stop_seen) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_ADV;
                    end
                end
            end

            S_FIN: begin
                state_nx = S_IDLE;
            end

            // The controller stays here until reset.
            S_ERROR: begin
                err_nx = 1'b1;
            end

            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs. The outputs are derived
    // from the next state so that each one lines up with its state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rem       <= '0;
            base      <= '0;
            expv      <= '0;
            stop_pend <= 1'b0;
            POS       <= '0;
            ERR       <= 1'b0;
            J         <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            rem       <= rem_nx;
            base      <= base_nx;
            expv      <= expv_nx;
            stop_pend <= stop_pend_nx;
            POS       <= pos_nx;
            ERR       <= err_nx;
            J         <= (state_nx == S_ADV);
            BUSY      <= (state_nx != S_IDLE) && (state_nx != S_ERROR);
            DONE      <= (state_nx == S_FIN);
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl.
// A behavioural 4-bit Gray counter sits on the J/K/QN side of the design.
// Runs are checked for advance count, DONE timing, POS and the ERR flag.
module tb_gray_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       STEP;
    logic       STOP;
    logic [7:0] STEPS;
    logic [3:0] QN;
    logic       J;
    logic       K;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [3:0] POS;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    gray_seq_ctrl #(
        .W     (4),
        .CNT_W (8)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .STEP  (STEP),
        .STOP  (STOP),
        .STEPS (STEPS),
        .QN    (QN),
        .J     (J),
        .K     (K),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR),
        .POS   (POS)
    );

    // Counter model: a position 0..15 plus a table of Gray codes. The table
    // is built by reflection: the list is mirrored, and the new MSB is set
    // on the mirrored half.
    logic [3:0] gray_tab [16];
    int         cnt        = 0;
    bit         stuck      = 1'b0;
    bit         preset     = 1'b0;
    int         preset_val = 0;

    initial begin
        gray_tab[0] = 4'd0;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < (1 << n); i++) begin
                gray_tab[(1 << n) + i] = gray_tab[(1 << n) - 1 - i] | 4'(1 << n);
            end
        end
    end

    always @(posedge CLK) begin
        if (preset) cnt <= preset_val;
        else if (J === 1'b1 && K === 1'b1 && !stuck) cnt <= (cnt + 1) % 16;
    end

    assign QN = gray_tab[cnt];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic set_cnt(input int v);
        @(negedge CLK);
        preset     = 1'b1;
        preset_val = v;
        @(negedge CLK);
        preset     = 1'b0;
    endtask

    // Launch a run, then watch it until BUSY drops. STOP is raised in the
    // ADV cycle of advance number stop_adv (0 = never).
    task automatic do_run(input bit s_start, input bit s_step, input int steps, input int stop_adv,
                          output int pulses, output int done_edge, output int done_cnt,
                          output int busy_first, output int jk_bad, output int edges);
        pulses = 0; done_edge = -1; done_cnt = 0; busy_first = 0; jk_bad = 0; edges = 0;
        @(negedge CLK);
        START = s_start;
        STEP  = s_step;
        STEPS = 8'(steps);
        for (int e = 1; e <= 1000; e++) begin
            @(negedge CLK);
            START = 1'b0;
            STEP  = 1'b0;
            STOP  = 1'b0;
            edges = e;
            if (J !== K) jk_bad++;
            if (e == 1) busy_first = int'(BUSY);
            if (J === 1'b1) begin
                pulses++;
                if (pulses == stop_adv) STOP = 1'b1;
            end
            if (DONE === 1'b1) begin
                done_cnt++;
                done_edge = e;
            end
            if (e > 1 && BUSY === 1'b0) break;
        end
    endtask

    initial begin
        int pulses, done_edge, done_cnt, busy_first, jk_bad, edges;
        int start_pos, steps, adv, stop_adv, want_adv, want_done, jcount;
        bit use_step;

        RST = 1'b1; START = 1'b0; STEP = 1'b0; STOP = 1'b0; STEPS = 8'd0;
        repeat (3) @(negedge CLK);
        chk("rst_j",    J,    0);
        chk("rst_k",    K,    0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err",  ERR,  0);
        chk("rst_pos",  POS,  0);
        RST = 1'b0;

        // Five steps from 0000.
        set_cnt(0);
        do_run(1, 0, 5, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t1_timeout", edges < 1000, 1);
        chk("t1_busy",    busy_first, 1);
        chk("t1_pulses",  pulses, 5);
        chk("t1_done_n",  done_cnt, 1);
        chk("t1_done_at", done_edge, 12);
        chk("t1_pos",     POS, 5);
        chk("t1_qn",      QN, 4'b0111);
        chk("t1_err",     ERR, 0);
        chk("t1_jk",      jk_bad, 0);

        // A single step from 1000 wraps to 0000.
        set_cnt(15);
        do_run(0, 1, 0, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t2_pulses",  pulses, 1);
        chk("t2_done_n",  done_cnt, 1);
        chk("t2_done_at", done_edge, 4);
        chk("t2_pos",     POS, 0);
        chk("t2_qn",      QN, 4'b0000);
        chk("t2_busy",    BUSY, 0);

        // Zero steps requested.
        set_cnt(9);
        do_run(1, 0, 0, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t3_pulses",  pulses, 0);
        chk("t3_done_at", done_edge, 2);
        chk("t3_pos",     POS, 9);

        // STOP during the third ADV of a ten-step run.
        set_cnt(6);
        do_run(1, 0, 10, 3, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t4_pulses", pulses, 3);
        chk("t4_done_n", done_cnt, 0);
        chk("t4_pos",    POS, 9);
        chk("t4_busy",   BUSY, 0);

        // Random runs compared against the step-counting model.
        for (int it = 0; it < 12; it++) begin
            start_pos = $urandom_range(0, 15);
            use_step  = 1'($urandom_range(0, 1));
            steps     = $urandom_range(0, 20);
            adv       = use_step ? 1 : steps;
            stop_adv  = 0;
            if (adv > 0 && $urandom_range(0, 1) == 1) stop_adv = $urandom_range(1, adv);
            want_adv  = (stop_adv > 0 && stop_adv < adv) ? stop_adv : adv;
            want_done = (stop_adv > 0 && stop_adv < adv) ? 0 : 1;
            set_cnt(start_pos);
            do_run(!use_step, use_step, steps, stop_adv,
                   pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
            chk("rnd_pulses", pulses, want_adv);
            chk("rnd_done_n", done_cnt, want_done);
            if (want_done == 1) chk("rnd_done_at", done_edge, 2 * adv + 2);
            chk("rnd_pos",    POS, (start_pos + want_adv) % 16);
            chk("rnd_err",    ERR, 0);
            chk("rnd_jk",     jk_bad, 0);
        end

        // Counter stuck at 0011: the readback check must flag it.
        set_cnt(2);
        stuck = 1'b1;
        do_run(0, 1, 0, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t5_pulses", pulses, 1);
        chk("t5_done_n", done_cnt, 0);
        chk("t5_err",    ERR, 1);
        chk("t5_busy",   BUSY, 0);
        chk("t5_pos",    POS, 2);
        jcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (J === 1'b1) jcount++;
            START = (c % 2 == 0);
            STEP  = (c % 3 == 0);
            STEPS = 8'd3;
        end
        @(negedge CLK);
        START = 1'b0;
        STEP  = 1'b0;
        @(negedge CLK);
        chk("t5_locked_j",   jcount, 0);
        chk("t5_locked_err", ERR, 1);
        chk("t5_locked_bsy", BUSY, 0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        stuck = 1'b0;
        chk("t5_rst_err", ERR, 0);
        chk("t5_rst_pos", POS, 0);

        // START and STEP together: START wins.
        start_pos = $urandom_range(0, 15);
        set_cnt(start_pos);
        do_run(1, 1, 4, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t6_pulses",  pulses, 4);
        chk("t6_done_at", done_edge, 10);
        chk("t6_pos",     POS, (start_pos + 4) % 16);

        // Reset in the middle of a run.
        @(negedge CLK);
        START = 1'b1;
        STEPS = 8'd10;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        chk("t6_mid_busy", BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t6_rst_j",    J, 0);
        chk("t6_rst_k",    K, 0);
        chk("t6_rst_busy", BUSY, 0);
        jcount = 0;
        repeat (4) begin
            @(negedge CLK);
            if (J === 1'b1) jcount++;
        end
        chk("t6_idle_j", jcount, 0);

        // Recovery: a single step from the position the counter was left at.
        start_pos = cnt;
        do_run(0, 1, 0, 0, pulses, done_edge, done_cnt, busy_first, jk_bad, edges);
        chk("t7_pulses", pulses, 1);
        chk("t7_pos",    POS, (start_pos + 1) % 16);
        chk("t7_done_n", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
